// File: rtl/pipe_reg.sv
// pipe_reg: elastic, parametrised pipeline register with valid/ready flow control,
// flush and occupancy count.
// Optional feature: define PIPE_REG_SKID_EN to add a one-entry skid register in
// front of stage 0, which decouples in_ready from out_ready.
module pipe_reg #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  input  logic                          out_ready,
  output logic [$clog2(STAGES+2)-1:0]   count
);

  localparam int unsigned CW = $clog2(STAGES + 2);

  // Stage 0 is the input side, STAGES-1 the output side.
  logic [STAGES-1:0] v_q;
  logic [WIDTH-1:0]  d_q [STAGES];

  logic              go;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] src_v;
  logic [WIDTH-1:0]  src_d [STAGES];

  // Source feeding stage 0 (input port, or the skid register when present).
  logic              head_v;
  logic [WIDTH-1:0]  head_d;
  logic              skid_cnt;

  assign go = en & ~flush;

  // Ready chain unrolled: a stage can load if any stage from it to the output is
  // empty, or the output is being taken. Equivalent to the rdy[i]=~v[i]|rdy[i+1]
  // recursion, written without a self-referencing vector.
  for (genvar i = 0; i < STAGES; i++) begin : g_rdy
    assign rdy[i] = go & (out_ready | ~(&v_q[STAGES-1:i]));
  end

  // Per-stage source selection.
  for (genvar i = 0; i < STAGES; i++) begin : g_src
    if (i == 0) begin : g_head
      assign src_v[i] = head_v;
      assign src_d[i] = head_d;
    end else begin : g_prev
      assign src_v[i] = v_q[i-1];
      assign src_d[i] = d_q[i-1];
    end
  end

`ifdef PIPE_REG_SKID_EN
  logic             sv_q;
  logic [WIDTH-1:0] sd_q;

  assign in_ready = ~sv_q & go;
  // A held skid entry always wins over the port; the port is not ready then anyway.
  assign head_v   = sv_q | in_valid;
  assign head_d   = sv_q ? sd_q : in_data;
  assign skid_cnt = sv_q;

  // Skid register: catch an accepted word that stage 0 cannot take, release it
  // as soon as stage 0 loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sv_q <= 1'b0;
      sd_q <= '0;
    end else if (en && flush) begin
      sv_q <= 1'b0;
    end else if (go) begin
      if (sv_q && rdy[0]) begin
        sv_q <= 1'b0;
      end else if (!sv_q && in_valid && !rdy[0]) begin
        sv_q <= 1'b1;
        sd_q <= in_data;
      end
    end
  end
`else
  assign in_ready = rdy[0];
  assign head_v   = in_valid;
  assign head_d   = in_data;
  assign skid_cnt = 1'b0;
`endif

  // Stage registers: load from the source when ready; flush kills valids but
  // keeps data; en low freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        d_q[i] <= '0;
      end
    end else if (en && flush) begin
      v_q <= '0;
    end else begin
      for (int i = 0; i < int'(STAGES); i++) begin
        if (rdy[i]) begin
          v_q[i] <= src_v[i];
          d_q[i] <= src_d[i];
        end
      end
    end
  end

  assign out_valid = v_q[STAGES-1] & ~flush;
  assign out_data  = d_q[STAGES-1];

  // Occupancy: popcount of stage valids plus the skid entry.
  always_comb begin
    count = CW'(skid_cnt);
    for (int i = 0; i < int'(STAGES); i++) begin
      count = count + CW'(v_q[i]);
    end
  end

endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: directed scoreboard bench for pipe_reg (WIDTH=32, STAGES=2).
// Accepted words are queued by the driver; a monitor pops and compares on every
// output transfer. Skid-specific vectors are enabled with PIPE_REG_SKID_EN.
module tb_pipe_reg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 2;
`ifdef PIPE_REG_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             en;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [1:0]       count;

  logic [WIDTH-1:0] exp_q[$];
  int               n_cmp;
  int               n_err;

  pipe_reg #(
    .WIDTH (WIDTH),
    .STAGES(STAGES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every output transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got 0x%0h, expected no transfer", out_data);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  // Drive one cycle's inputs (just after a rising edge), then at the falling
  // edge check in_ready and update the scoreboard.
  task automatic cyc_begin(input bit iv, input logic [31:0] id, input bit ordy, input bit e,
                           input bit fl, input bit exp_rdy);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    en        = e;
    flush     = fl;
    @(negedge clk);
    check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    if (iv && exp_rdy) exp_q.push_back(id);
    if (fl && e) exp_q.delete();
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit iv, input logic [31:0] id, input bit ordy, input bit e,
                     input bit fl, input bit exp_rdy);
    cyc_begin(iv, id, ordy, e, fl, exp_rdy);
    cyc_end();
  endtask

  task automatic chk_count(input string name, input int exp);
    check(name, {30'b0, count}, exp);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    en        = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset state.
    #2;
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_data", out_data, 0);
    chk_count("rst_count", 0);
    check("rst_in_ready", {31'b0, in_ready}, 1);
    @(negedge clk);
    rst = 1'b0;
    cyc_end();

    // Stream 0x11, 0x22, 0x33 with out_ready high.
    cyc(1, 32'h11, 1, 1, 0, 1);
    chk_count("s_count1", 1);
    check("s_lat_not_yet", {31'b0, out_valid}, 0);
    cyc(1, 32'h22, 1, 1, 0, 1);
    check("s_lat_valid", {31'b0, out_valid}, 1);
    chk_count("s_count2", 2);
    cyc(1, 32'h33, 1, 1, 0, 1);
    chk_count("s_count3", 2);
    cyc(0, 0, 1, 1, 0, 1);
    cyc(0, 0, 1, 1, 0, 1);
    cyc(0, 0, 1, 1, 0, 1);
    chk_count("s_drained", 0);
    check("s_queue_empty", exp_q.size(), 0);

    // Back-pressure fill, then a simultaneous accept and transfer.
    cyc(1, 32'hA, 0, 1, 0, 1);
    chk_count("bp_count1", 1);
    cyc(1, 32'hB, 0, 1, 0, 1);
    chk_count("bp_full", 2);
    cyc(0, 0, 0, 1, 0, SKID ? 1'b1 : 1'b0);
    chk_count("bp_hold", 2);
    cyc(1, 32'hC, 1, 1, 0, 1);
    chk_count("bp_swap", 2);
    cyc(0, 0, 1, 1, 0, 1);
    cyc(0, 0, 1, 1, 0, 1);
    chk_count("bp_drained", 0);
    check("bp_queue_empty", exp_q.size(), 0);

    // Flush with two entries held.
    cyc(1, 32'h44, 0, 1, 0, 1);
    cyc(1, 32'h66, 0, 1, 0, 1);
    chk_count("fl_pre", 2);
    cyc_begin(1, 32'h77, 1, 1, 1, 0);
    check("fl_out_valid_during", {31'b0, out_valid}, 0);
    check("fl_out_data_during", out_data, 32'h44);
    cyc_end();
    chk_count("fl_count_after", 0);
    check("fl_out_valid_after", {31'b0, out_valid}, 0);
    check("fl_out_data_after", out_data, 32'h44);
    cyc(0, 0, 1, 1, 0, 1);
    chk_count("fl_stays_empty", 0);

    // Enable freeze for three cycles with traffic offered on both sides.
    cyc(1, 32'h81, 0, 1, 0, 1);
    cyc(1, 32'h82, 0, 1, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cyc_begin(1, 32'h8F, 1, 0, 0, 0);
      check("en_out_valid", {31'b0, out_valid}, 1);
      check("en_out_data", out_data, 32'h81);
      cyc_end();
      chk_count("en_count", 2);
    end
    cyc(1, 32'h83, 1, 1, 0, 1);
    cyc(0, 0, 1, 1, 0, 1);
    cyc(0, 0, 1, 1, 0, 1);
    chk_count("en_drained", 0);
    check("en_queue_empty", exp_q.size(), 0);

    // Asynchronous reset pulsed between edges.
    cyc(1, 32'h91, 0, 1, 0, 1);
    cyc(1, 32'h92, 0, 1, 0, 1);
    chk_count("ar_pre", 2);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("ar_out_valid", {31'b0, out_valid}, 0);
    chk_count("ar_count", 0);
    check("ar_out_data", out_data, 0);
    exp_q.delete();
    #1;
    rst = 1'b0;
    cyc_end();
    cyc(1, 32'hA1, 1, 1, 0, 1);
    cyc(0, 0, 1, 1, 0, 1);
    cyc(0, 0, 1, 1, 0, 1);
    chk_count("ar_recovered", 0);
    check("ar_queue_empty", exp_q.size(), 0);

`ifdef PIPE_REG_SKID_EN
    // Full pipe with out_ready low: the next word lands in the skid register.
    cyc(1, 32'h51, 0, 1, 0, 1);
    cyc(1, 32'h52, 0, 1, 0, 1);
    chk_count("sk_full", 2);
    cyc(1, 32'h55, 0, 1, 0, 1);
    chk_count("sk_count", STAGES + 1);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    chk_count("sk_drain1", 2);
    cyc(0, 0, 1, 1, 0, 1);
    cyc(0, 0, 1, 1, 0, 1);
    chk_count("sk_drained", 0);
    check("sk_queue_empty", exp_q.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
